mem_arbiter: RTL and testbench

Shares the single byte-lane data RAM (combinational read, posedge write, word-indexed by addr[18:2]) between the instruction-fetch port and the MEM-stage load/store port. It accepts level requests from both ports, picks a winner, drives one RAM access from latched request registers, then returns a registered ack and registered read data. It also generates pipeline stall signals. MEM has priority, bounded by a starvation limit that protects fetch.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one shared byte-lane data RAM between the fetch port and the MEM load/store port.
// MEM has priority; a saturating counter forces a fetch grant after STARVE_LIMIT MEM grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stall_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        owner_mem_q, owner_mem_d;
  logic [3:0]  starve_q, starve_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        grant_mem;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    owner_mem_d = owner_mem_q;
    starve_d    = starve_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    grant_mem   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!if_req_i) starve_d = '0;
        if (if_req_i || mem_req_i) begin
          grant_mem   = mem_req_i && !(if_req_i && (starve_q == Limit));
          owner_mem_d = grant_mem;
          state_d     = StAccess;
          if (grant_mem) begin
            addr_d  = mem_addr_i;
            sel_d   = mem_sel_i;
            wdata_d = mem_wdata_i;
            we_d    = mem_we_i;
            if (if_req_i) starve_d = (starve_q >= Limit) ? Limit : starve_q + 4'd1;
          end else begin
            addr_d   = if_addr_i;
            sel_d    = 4'b1111;
            we_d     = 1'b0;
            starve_d = '0;
          end
        end
      end
      StAccess: begin
        // Read data and the ack are both registered so they appear together in StDone.
        if (!we_q) begin
          if (owner_mem_q) mem_rdata_d = ram_rdata_i;
          else             if_rdata_d  = ram_rdata_i;
        end
        if (owner_mem_q) mem_ack_d = 1'b1;
        else             if_ack_d  = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      owner_mem_q <= 1'b0;
      starve_q    <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      owner_mem_q <= owner_mem_d;
      starve_q    <= starve_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_ce_o    = (state_q == StAccess);
  assign ram_we_o    = ram_ce_o && we_q;
  assign ram_addr_o  = addr_q;
  assign ram_sel_o   = sel_q;
  assign ram_wdata_o = wdata_q;

  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_stall_o  = if_req_i && !if_ack_q;
  assign mem_stall_o = mem_req_i && !mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences and
// a randomized run checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_ack, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ack_o   (if_ack),
    .if_rdata_o (if_rdata),
    .if_stall_o (if_stall),
    .mem_req_i  (mem_req),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_sel_i  (mem_sel),
    .mem_wdata_i(mem_wdata),
    .mem_ack_o  (mem_ack),
    .mem_rdata_o(mem_rdata),
    .mem_stall_o(mem_stall),
    .ram_ce_o   (ram_ce),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_sel_o  (ram_sel),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Environment RAM: combinational read, posedge byte-lane write.
  logic [31:0] ram_mem   [0:1023];
  logic [31:0] model_mem [0:1023];
  logic        mem_load;

  assign ram_rdata = ram_mem[ram_addr[11:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= model_mem[i];
    end else if (ram_ce && ram_we) begin
      ram_mem[ram_addr[11:2]] <= merge(ram_mem[ram_addr[11:2]], ram_wdata, ram_sel);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst if_ack", if_ack, 0);
    chk("rst mem_ack", mem_ack, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst ram_ce", ram_ce, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_sel", ram_sel, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // owner's rdata after the transaction
    logic [31:0] exp_word;   // RAM word after the transaction
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] exp_ifr, exp_memr;

  // One isolated transaction: ack must land exactly two cycles after acceptance.
  task automatic run_one(input int id, input vec_t v);
    int   lat;
    logic got;
    @(negedge clk);
    if (v.is_if) begin
      if_req = 1'b1;
      if_addr = v.addr;
    end else begin
      mem_req = 1'b1;
      mem_we = v.we;
      mem_addr = v.addr;
      mem_sel = v.sel;
      mem_wdata = v.wdata;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk($sformatf("vec%0d ram_ce", id), ram_ce, 1);
        chk($sformatf("vec%0d ram_we", id), ram_we, v.is_if ? 1'b0 : v.we);
        chk($sformatf("vec%0d ram_addr", id), ram_addr, v.addr);
        chk($sformatf("vec%0d ram_sel", id), ram_sel, v.is_if ? 4'hf : v.sel);
      end
      got = v.is_if ? if_ack : mem_ack;
      chk($sformatf("vec%0d other ack", id), v.is_if ? mem_ack : if_ack, 0);
    end
    chk($sformatf("vec%0d ack latency", id), lat, 2);
    if_req = 1'b0;
    mem_req = 1'b0;
    if (v.is_if) exp_ifr = v.exp_rdata;
    else         exp_memr = v.exp_rdata;
    chk($sformatf("vec%0d if_rdata", id), if_rdata, exp_ifr);
    chk($sformatf("vec%0d mem_rdata", id), mem_rdata, exp_memr);
    chk($sformatf("vec%0d ram word", id), ram_mem[v.addr[11:2]], v.exp_word);
  endtask

  // Reference model state for the randomized run.
  int          free_at, ack_at;
  logic        own_mem, l_we;
  logic [31:0] l_addr, l_wdata;
  logic [3:0]  l_sel;
  int          stv;
  logic        e_if_ack, e_mem_ack;

  initial begin
    rst = 1'b1;
    mem_load = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h5A5A_0000 + i;
    model_mem[4]  = 32'hDEAD_BEEF;
    model_mem[8]  = 32'h1122_3344;
    model_mem[12] = 32'hA5A5_A5A5;
    model_mem[16] = 32'h5566_7788;
    @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;

    // Single fetch timing and stall window.
    do_reset();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h10;
    #1 chk("fetch stall c1", if_stall, 1);
    @(negedge clk);
    chk("fetch stall c2", if_stall, 1);
    chk("fetch ram_ce c2", ram_ce, 1);
    chk("fetch ack c2", if_ack, 0);
    @(negedge clk);
    chk("fetch ack c3", if_ack, 1);
    chk("fetch rdata c3", if_rdata, 32'hDEAD_BEEF);
    chk("fetch stall c3", if_stall, 0);
    chk("fetch ram_ce c3", ram_ce, 0);
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch ack c4", if_ack, 0);

    // Directed vector table.
    do_reset();
    exp_ifr = '0;
    exp_memr = '0;
    vecs[0] = '{1'b1, 1'b0, 32'h10, 4'h0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h20, 4'h4, 32'h00AB_0000, 32'h0,         32'h11AB_3344};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 4'hf, 32'h0,         32'h11AB_3344, 32'h11AB_3344};
    vecs[3] = '{1'b0, 1'b1, 32'h30, 4'h0, 32'hFFFF_FFFF, 32'h11AB_3344, 32'hA5A5_A5A5};
    vecs[4] = '{1'b0, 1'b0, 32'h30, 4'hf, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 1'b0, 32'h20, 4'h0, 32'h0,         32'h11AB_3344, 32'h11AB_3344};
    vecs[6] = '{1'b0, 1'b1, 32'h30, 4'hf, 32'h1234_5678, 32'hA5A5_A5A5, 32'h1234_5678};
    vecs[7] = '{1'b0, 1'b1, 32'h30, 4'h9, 32'hAABB_CCDD, 32'hA5A5_A5A5, 32'hAA34_56DD};
    vecs[8] = '{1'b0, 1'b0, 32'h33, 4'hf, 32'h0,         32'hAA34_56DD, 32'hAA34_56DD};
    for (int i = 0; i < 9; i++) run_one(i, vecs[i]);

    // Tie with counter at zero: MEM acked in cycle 3, fetch in cycle 6.
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mem_sel = 4'hf;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("tie mem_ack c%0d", c), mem_ack, (c == 3) ? 1 : 0);
      chk($sformatf("tie if_ack c%0d", c), if_ack, (c == 6) ? 1 : 0);
      if (mem_ack) mem_req = 1'b0;
      if (if_ack) if_req = 1'b0;
    end

    // Starvation: both held high; every (Limit+1)-th ack goes to fetch.
    do_reset();
    @(negedge clk);
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    begin
      int k = 0;
      int cyc = 0;
      while (k < 2 * (Limit + 1) && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (if_ack || mem_ack) begin
          chk($sformatf("starve ack%0d is_if", k), if_ack,
              ((k % (Limit + 1)) == Limit) ? 1 : 0);
          k++;
        end
      end
      chk("starve ack count", k, 2 * (Limit + 1));
    end
    if_req = 1'b0; mem_req = 1'b0;

    // Reset during the access of a full-word store.
    do_reset();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_sel = 4'hf; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstacc ram_we before", ram_we, 1);
    rst = 1'b1;
    #1;
    chk("rstacc ram_we", ram_we, 0);
    chk("rstacc ram_ce", ram_ce, 0);
    chk("rstacc mem_ack", mem_ack, 0);
    chk("rstacc ram_addr", ram_addr, 0);
    chk("rstacc mem_rdata", mem_rdata, 0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    begin
      int acks = 0;
      repeat (4) begin
        @(negedge clk);
        if (if_ack || mem_ack) acks++;
      end
      chk("rstacc no ack", acks, 0);
    end
    chk("rstacc word", ram_mem[16], 32'h5566_7788);
    exp_ifr = '0;
    exp_memr = '0;
    run_one(100, '{1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 32'h5566_7788, 32'h5566_7788});

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 1024; i++) model_mem[i] = ram_mem[i];
    exp_ifr = '0; exp_memr = '0;
    free_at = 0; ack_at = -1; stv = 0; own_mem = 1'b0;
    l_we = 1'b0; l_addr = '0; l_wdata = '0; l_sel = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      e_if_ack  = (ack_at == cyc) && !own_mem;
      e_mem_ack = (ack_at == cyc) && own_mem;
      if (ack_at == cyc) begin
        if (l_we) model_mem[l_addr[11:2]] = merge(model_mem[l_addr[11:2]], l_wdata, l_sel);
        else if (own_mem) exp_memr = model_mem[l_addr[11:2]];
        else exp_ifr = model_mem[l_addr[11:2]];
      end
      chk("rnd if_ack", if_ack, e_if_ack);
      chk("rnd mem_ack", mem_ack, e_mem_ack);
      chk("rnd if_stall", if_stall, if_req && !e_if_ack);
      chk("rnd mem_stall", mem_stall, mem_req && !e_mem_ack);
      chk("rnd if_rdata", if_rdata, exp_ifr);
      chk("rnd mem_rdata", mem_rdata, exp_memr);
      if (e_if_ack) if_req = 1'b0;
      if (e_mem_ack) mem_req = 1'b0;
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1;
        if_addr = 32'($urandom_range(0, 255));
      end
      if (!mem_req && $urandom_range(0, 3) != 0) begin
        mem_req = 1'b1;
        mem_we = 1'($urandom_range(0, 1));
        mem_addr = 32'($urandom_range(0, 255));
        mem_sel = 4'($urandom_range(0, 15));
        mem_wdata = $urandom;
      end
      // Grant decision for a request seen at the edge ending this cycle.
      if (cyc >= free_at) begin
        if (!if_req) stv = 0;
        if (if_req || mem_req) begin
          own_mem = mem_req && !(if_req && stv == Limit);
          if (own_mem) begin
            l_we = mem_we; l_addr = mem_addr; l_sel = mem_sel; l_wdata = mem_wdata;
            if (if_req) stv = (stv >= Limit) ? Limit : stv + 1;
          end else begin
            l_we = 1'b0; l_addr = if_addr; l_sel = 4'hf;
            stv = 0;
          end
          ack_at = cyc + 2;
          free_at = cyc + 3;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
